// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - shared constants, state types and helpers for the MIDI transmitter
package midi_pkg;

  localparam int         MIDI_BAUD       = 31250;
  localparam logic [7:0] MIDI_STATUS_MIN = 8'h80;
  localparam logic [7:0] MIDI_CHAN_MAX   = 8'hEF;
  localparam logic [7:0] MIDI_SYSCOM_MAX = 8'hF7;

  // Message sequencer: which byte of the message is on the line
  typedef enum logic [1:0] {
    MSG_IDLE   = 2'd0,
    MSG_STATUS = 2'd1,
    MSG_DATA1  = 2'd2,
    MSG_DATA2  = 2'd3
  } msg_state_t;

  // Byte serializer: which part of the 8N1 frame is on the line
  typedef enum logic [1:0] {
    BIT_IDLE  = 2'd0,
    BIT_START = 2'd1,
    BIT_DATA  = 2'd2,
    BIT_STOP  = 2'd3
  } bit_state_t;

  // Channel voice/mode status bytes are the only ones eligible for running status
  function automatic logic is_chan_status(input logic [7:0] s);
    return (s >= MIDI_STATUS_MIN) && (s <= MIDI_CHAN_MAX);
  endfunction

endpackage

// File: rtl/midi_byte_tx.sv
// rtl/midi_byte_tx.sv - 8N1 LSB-first byte serializer with back-to-back restart
module midi_byte_tx
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       byte_done,
  output logic       idle
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  bit_state_t    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tx_q;

  // byte_done marks the final cycle of the stop bit so the next frame can start on the very next edge
  assign byte_done = (state == BIT_STOP) && (cnt == CNT_LAST);
  assign idle      = (state == BIT_IDLE);
  assign tx        = tx_q;

  // Frame sequencing: tx is registered together with the state so each level lasts exactly one bit period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BIT_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
    end else if (start && (idle || byte_done)) begin
      state   <= BIT_START;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= data;
      tx_q    <= 1'b0;
    end else if (state != BIT_IDLE) begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        case (state)
          BIT_START: begin
            state <= BIT_DATA;
            tx_q  <= shreg[0];
            shreg <= shreg >> 1;
          end
          BIT_DATA: begin
            if (bit_idx == 3'd7) begin
              state <= BIT_STOP;
              tx_q  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_q    <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
          default: begin
            state <= BIT_IDLE;
            tx_q  <= 1'b1;
          end
        endcase
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/midi_tx.sv
// rtl/midi_tx.sv - MIDI 1.0 message transmitter with optional running-status compression
module midi_tx
  import midi_pkg::*;
#(
  parameter int CLK_RATE  = 50000000,
  parameter int BAUD_RATE = MIDI_BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       msg_valid,
  output logic       msg_ready,
  input  logic [7:0] msg_status,
  input  logic [6:0] msg_data1,
  input  logic [6:0] msg_data2,
  input  logic [1:0] msg_len,
  input  logic       rs_en,
  output logic       tx,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_RATE / BAUD_RATE;

  msg_state_t state;
  logic [6:0] data1_q;
  logic [6:0] data2_q;
  logic [1:0] len_q;
  logic [7:0] last_status;
  logic       drop_q;

  logic       accept;
  logic       valid_status;
  logic [1:0] len_norm;
  logic       suppress;
  logic       more_bytes;
  logic       byte_start;
  logic [7:0] byte_data;
  logic       byte_done;
  logic       byte_idle;

  // drop_q holds ready low for the one cycle after a non-status byte is swallowed
  assign msg_ready    = (state == MSG_IDLE) && !drop_q && byte_idle;
  assign busy         = (state != MSG_IDLE);
  assign accept       = msg_valid && msg_ready;
  assign valid_status = msg_status[7];
  assign len_norm     = (msg_len == 2'd0) ? 2'd1 : msg_len;
  assign suppress     = rs_en && is_chan_status(msg_status) &&
                        (msg_status == last_status) && (len_norm >= 2'd2);

  // Whether the byte finishing now is followed by another byte of the same message
  always_comb begin
    more_bytes = 1'b0;
    case (state)
      MSG_STATUS: more_bytes = (len_q >= 2'd2);
      MSG_DATA1:  more_bytes = (len_q == 2'd3);
      default:    more_bytes = 1'b0;
    endcase
  end

  // The first byte comes straight from the inputs so the start bit begins on the accept edge
  assign byte_start = (accept && valid_status) || (byte_done && more_bytes);

  // Select the byte handed to the serializer; data bytes always go out with bit 7 clear
  always_comb begin
    byte_data = msg_status;
    if (accept) begin
      byte_data = suppress ? {1'b0, msg_data1} : msg_status;
    end else if (state == MSG_STATUS) begin
      byte_data = {1'b0, data1_q};
    end else begin
      byte_data = {1'b0, data2_q};
    end
  end

  // Message sequencer: capture at accept, then step one byte per serializer completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= MSG_IDLE;
      data1_q <= '0;
      data2_q <= '0;
      len_q   <= 2'd1;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= accept && !valid_status;
      if (accept && valid_status) begin
        data1_q <= msg_data1;
        data2_q <= msg_data2;
        len_q   <= len_norm;
        state   <= suppress ? MSG_DATA1 : MSG_STATUS;
      end else if (byte_done) begin
        case (state)
          MSG_STATUS: state <= (len_q >= 2'd2) ? MSG_DATA1 : MSG_IDLE;
          MSG_DATA1:  state <= (len_q == 2'd3) ? MSG_DATA2 : MSG_IDLE;
          default:    state <= MSG_IDLE;
        endcase
      end
    end
  end

  // Running-status memory: channel statuses are remembered, system common cancels, realtime is transparent
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_status <= 8'h00;
    end else if (accept && valid_status) begin
      if (is_chan_status(msg_status)) begin
        last_status <= msg_status;
      end else if (msg_status <= MIDI_SYSCOM_MAX) begin
        last_status <= 8'h00;
      end
    end
  end

  midi_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (byte_start),
    .data     (byte_data),
    .tx       (tx),
    .byte_done(byte_done),
    .idle     (byte_idle)
  );

endmodule

// File: tb/tb_midi_tx.sv
// tb/tb_midi_tx.sv - randomized and directed self-checking bench for midi_tx
module tb_midi_tx;

  localparam int CPB  = 16;
  localparam int CPBD = 1600;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       msg_valid, msg_ready, rs_en, tx, busy;
  logic [7:0] msg_status;
  logic [6:0] msg_data1, msg_data2;
  logic [1:0] msg_len;

  logic       d_valid, d_ready, d_tx, d_busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] model_last;
  logic [7:0] exp_q[$];
  logic [9:0] cap_q[$];

  always #5 clk = ~clk;

  midi_tx #(.CLK_RATE(CPB * 31250), .BAUD_RATE(31250)) dut (
    .clk(clk), .rst_n(rst_n), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_status(msg_status), .msg_data1(msg_data1), .msg_data2(msg_data2),
    .msg_len(msg_len), .rs_en(rs_en), .tx(tx), .busy(busy)
  );

  midi_tx dut_def (
    .clk(clk), .rst_n(rst_n), .msg_valid(d_valid), .msg_ready(d_ready),
    .msg_status(8'h90), .msg_data1(7'h3C), .msg_data2(7'h64),
    .msg_len(2'd3), .rs_en(1'b0), .tx(d_tx), .busy(d_busy)
  );

  // Reference: bytes a MIDI sender puts on the wire for one message, with running status
  task automatic model_msg(input logic [7:0] st, input logic [6:0] d1, input logic [6:0] d2,
                           input logic [1:0] len, input logic rs);
    int n;
    exp_q.delete();
    n = (len == 2'd0) ? 1 : int'(len);
    if (!st[7]) return;
    if (!(rs && st >= 8'h80 && st <= 8'hEF && st == model_last && n >= 2)) exp_q.push_back(st);
    if (n >= 2) exp_q.push_back({1'b0, d1});
    if (n == 3) exp_q.push_back({1'b0, d2});
    if (st <= 8'hEF) model_last = st;
    else if (st <= 8'hF7) model_last = 8'h00;
  endtask

  // Drive one message and record ready-low cycles plus the 10-bit frames seen at bit centres
  task automatic transmit(input logic [7:0] st, input logic [6:0] d1, input logic [6:0] d2,
                          input logic [1:0] len, input logic rs,
                          output int low, output logic rdy_after);
    logic [9:0] frame;
    int bitv;
    @(negedge clk);
    msg_status = st; msg_data1 = d1; msg_data2 = d2; msg_len = len; rs_en = rs;
    msg_valid = 1'b1;
    for (int i = 0; i < 4000 && !msg_ready; i++) @(negedge clk);
    @(posedge clk); #1;
    msg_valid = 1'b0;
    low = 0; frame = '0;
    cap_q.delete();
    for (int c = 0; c < 20000; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (msg_ready) break;
      low++;
      if (c % CPB == CPB / 2) begin
        bitv = c / CPB;
        frame[bitv % 10] = tx;
        if (bitv % 10 == 9) cap_q.push_back(frame);
      end
    end
    rdy_after = msg_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; msg_valid = 1'b0; d_valid = 1'b0; rs_en = 1'b0;
    msg_status = '0; msg_data1 = '0; msg_data2 = '0; msg_len = '0;
    model_last = 8'h00;
    repeat (3) @(posedge clk); #1;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", tx); end
    total++; if (msg_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", msg_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (msg_ready !== 1'b1 || tx !== 1'b1) begin bad++; $display("FAIL post_reset_idle got=%b%b exp=11", msg_ready, tx); end
  endtask

  task automatic test_note_on();
    int low; logic rdy;
    model_msg(8'h90, 7'h3C, 7'h64, 2'd3, 1'b0);
    transmit(8'h90, 7'h3C, 7'h64, 2'd3, 1'b0, low, rdy);
    total++; if (low !== 480) begin bad++; $display("FAIL note_on_ready_low got=%0d exp=480", low); end
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL note_on_ready_after got=%b exp=1", rdy); end
    total++; if (cap_q.size() !== 3) begin bad++; $display("FAIL note_on_nbytes got=%0d exp=3", cap_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= cap_q.size() || cap_q[i] !== {1'b1, exp_q[i], 1'b0}) begin
        bad++; $display("FAIL note_on_frame%0d got=%h exp=%h", i, (i < cap_q.size()) ? cap_q[i] : 10'h0, {1'b1, exp_q[i], 1'b0});
      end
    end
  endtask

  // Each row: status, data1, data2, len, rs_en, bytes expected on the wire
  task automatic test_running_status();
    logic [7:0] st[5]; logic [6:0] d1[5]; logic [6:0] d2[5]; logic [1:0] ln[5]; logic rs[5]; int nb[5];
    int low; logic rdy;
    st = '{8'h90, 8'h80, 8'h90, 8'hF8, 8'h90}; d1 = '{7'h3C, 7'h3C, 7'h40, 7'h00, 7'h41};
    d2 = '{7'h64, 7'h00, 7'h10, 7'h00, 7'h11}; ln = '{2'd3, 2'd3, 2'd3, 2'd1, 2'd3};
    rs = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};     nb = '{2, 3, 3, 1, 2};
    for (int k = 0; k < 5; k++) begin
      model_msg(st[k], d1[k], d2[k], ln[k], rs[k]);
      transmit(st[k], d1[k], d2[k], ln[k], rs[k], low, rdy);
      total++; if (low !== nb[k] * 10 * CPB) begin bad++; $display("FAIL rs%0d_ready_low got=%0d exp=%0d", k, low, nb[k] * 10 * CPB); end
      total++; if (cap_q.size() !== nb[k]) begin bad++; $display("FAIL rs%0d_nbytes got=%0d exp=%0d", k, cap_q.size(), nb[k]); end
      foreach (exp_q[i]) begin
        total++;
        if (i >= cap_q.size() || cap_q[i] !== {1'b1, exp_q[i], 1'b0}) begin
          bad++; $display("FAIL rs%0d_frame%0d got=%h exp=%h", k, i, (i < cap_q.size()) ? cap_q[i] : 10'h0, {1'b1, exp_q[i], 1'b0});
        end
      end
    end
  endtask

  task automatic test_syscom_clears();
    logic [7:0] st[3]; int nb[3];
    int low; logic rdy;
    st = '{8'h90, 8'hF2, 8'h90}; nb = '{2, 3, 3};
    for (int k = 0; k < 3; k++) begin
      model_msg(st[k], 7'h22, 7'h33, 2'd3, 1'b1);
      transmit(st[k], 7'h22, 7'h33, 2'd3, 1'b1, low, rdy);
      total++; if (cap_q.size() !== nb[k]) begin bad++; $display("FAIL syscom%0d_nbytes got=%0d exp=%0d", k, cap_q.size(), nb[k]); end
      foreach (exp_q[i]) begin
        total++;
        if (i >= cap_q.size() || cap_q[i] !== {1'b1, exp_q[i], 1'b0}) begin
          bad++; $display("FAIL syscom%0d_frame%0d got=%h exp=%h", k, i, (i < cap_q.size()) ? cap_q[i] : 10'h0, {1'b1, exp_q[i], 1'b0});
        end
      end
    end
  endtask

  task automatic test_drop();
    int low; logic rdy;
    model_msg(8'h45, 7'h01, 7'h02, 2'd3, 1'b1);
    transmit(8'h45, 7'h01, 7'h02, 2'd3, 1'b1, low, rdy);
    total++; if (low !== 1) begin bad++; $display("FAIL drop_ready_low got=%0d exp=1", low); end
    total++; if (cap_q.size() !== 0 || tx !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL drop_quiet got=%0d/%b/%b exp=0/1/0", cap_q.size(), tx, busy);
    end
    model_msg(8'h90, 7'h05, 7'h06, 2'd3, 1'b1);
    transmit(8'h90, 7'h05, 7'h06, 2'd3, 1'b1, low, rdy);
    total++; if (cap_q.size() !== 2) begin bad++; $display("FAIL drop_keeps_status got=%0d exp=2", cap_q.size()); end
  endtask

  task automatic test_reset_midframe();
    int low; logic rdy;
    @(negedge clk);
    msg_status = 8'h90; msg_data1 = 7'h3C; msg_data2 = 7'h64; msg_len = 2'd3; rs_en = 1'b0;
    msg_valid = 1'b1;
    for (int i = 0; i < 4000 && !msg_ready; i++) @(negedge clk);
    @(posedge clk); #1;
    msg_valid = 1'b0;
    repeat (4 * CPB + CPB / 2) @(posedge clk);
    #1;
    total++; if (tx !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL midframe_bit3 got=%b%b exp=01", tx, busy); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL midreset_tx got=%b exp=1", tx); end
    total++; if (busy !== 1'b0 || msg_ready !== 1'b1) begin bad++; $display("FAIL midreset_state got=%b%b exp=01", busy, msg_ready); end
    @(negedge clk); rst_n = 1'b1;
    model_last = 8'h00;
    model_msg(8'h90, 7'h3C, 7'h64, 2'd3, 1'b1);
    transmit(8'h90, 7'h3C, 7'h64, 2'd3, 1'b1, low, rdy);
    total++; if (cap_q.size() !== 3) begin bad++; $display("FAIL after_reset_nbytes got=%0d exp=3", cap_q.size()); end
    total++; if (cap_q.size() > 0 && cap_q[0] !== {1'b1, 8'h90, 1'b0}) begin bad++; $display("FAIL after_reset_status got=%h exp=%h", cap_q[0], {1'b1, 8'h90, 1'b0}); end
  endtask

  task automatic test_back_to_back();
    int low;
    @(negedge clk);
    msg_status = 8'hFE; msg_len = 2'd0; rs_en = 1'b0; msg_valid = 1'b1;
    for (int i = 0; i < 4000 && !msg_ready; i++) @(negedge clk);
    @(posedge clk); #1;
    low = 0;
    for (int c = 0; c < 4000 && !msg_ready; c++) begin low++; @(posedge clk); #1; end
    total++; if (low !== 10 * CPB) begin bad++; $display("FAIL len0_ready_low got=%0d exp=%0d", low, 10 * CPB); end
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL gap_idle_tx got=%b exp=1", tx); end
    @(posedge clk); #1;
    total++; if (tx !== 1'b0 || msg_ready !== 1'b0) begin bad++; $display("FAIL gap_next_start got=%b%b exp=00", tx, msg_ready); end
    msg_valid = 1'b0;
    for (int c = 0; c < 4000 && !msg_ready; c++) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [7:0] pool[8];
    logic [7:0] st; logic [6:0] d1, d2; logic [1:0] ln; logic rs;
    int low; logic rdy; int el;
    pool = '{8'h90, 8'h90, 8'h80, 8'hB3, 8'hF8, 8'hF2, 8'h45, 8'hF0};
    for (int k = 0; k < 14; k++) begin
      st = pool[$urandom_range(0, 7)];
      d1 = 7'($urandom); d2 = 7'($urandom); ln = 2'($urandom); rs = 1'($urandom);
      model_msg(st, d1, d2, ln, rs);
      transmit(st, d1, d2, ln, rs, low, rdy);
      el = (exp_q.size() == 0) ? 1 : exp_q.size() * 10 * CPB;
      total++; if (low !== el) begin bad++; $display("FAIL rand%0d_ready_low st=%h got=%0d exp=%0d", k, st, low, el); end
      total++; if (cap_q.size() !== exp_q.size()) begin bad++; $display("FAIL rand%0d_nbytes got=%0d exp=%0d", k, cap_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
        total++;
        if (i >= cap_q.size() || cap_q[i] !== {1'b1, exp_q[i], 1'b0}) begin
          bad++; $display("FAIL rand%0d_frame%0d got=%h exp=%h", k, i, (i < cap_q.size()) ? cap_q[i] : 10'h0, {1'b1, exp_q[i], 1'b0});
        end
      end
    end
  endtask

  task automatic test_default();
    logic [9:0] frame; logic [7:0] ex[3];
    int low, bitv, nf;
    ex = '{8'h90, 8'h3C, 8'h64};
    @(negedge clk); d_valid = 1'b1;
    for (int i = 0; i < 4000 && !d_ready; i++) @(negedge clk);
    @(posedge clk); #1;
    d_valid = 1'b0;
    low = 0; nf = 0; frame = '0;
    for (int c = 0; c < 60000; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (d_ready) break;
      low++;
      if (c % CPBD == CPBD / 2) begin
        bitv = c / CPBD;
        frame[bitv % 10] = d_tx;
        if (bitv % 10 == 9) begin
          total++;
          if (nf > 2 || frame !== {1'b1, ex[nf % 3], 1'b0}) begin bad++; $display("FAIL default_frame%0d got=%h exp=%h", nf, frame, {1'b1, ex[nf % 3], 1'b0}); end
          nf++;
        end
      end
    end
    total++; if (low !== 48000) begin bad++; $display("FAIL default_ready_low got=%0d exp=48000", low); end
    total++; if (nf !== 3 || d_busy !== 1'b0) begin bad++; $display("FAIL default_done got=%0d/%b exp=3/0", nf, d_busy); end
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_running_status();
    test_syscom_clears();
    test_drop();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    test_default();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/midi_tx.md
# midi_tx

MIDI 1.0 serial transmitter: accepts whole MIDI messages (status plus 0–2 data bytes) over a valid/ready handshake and serializes them on a 31250-baud current-loop-ready TX line (8N1, LSB first). Optional running-status compression applies to channel messages. It is the sending end of the MIDI link whose input the top level already routes. It sits beside `reg_ctrl`, which drives the message port, so the board can echo or forward note events to external gear.

## Interface
Parameters:
- `CLK_RATE`, default 50000000: clock frequency in Hz.
- `BAUD_RATE`, default 31250: MIDI bit rate. `CLKS_PER_BIT = CLK_RATE/BAUD_RATE` (integer divide; 1600 at defaults).

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `msg_valid`  in  1: message present on `msg_*`.
- `msg_ready`  out  1: block can accept a message.
- `msg_status`  in  8: status byte.
- `msg_data1`  in  7: first data byte; bit 7 is transmitted as 0.
- `msg_data2`  in  7: second data byte.
- `msg_len`  in  2: bytes in message. 1 = status only, 2 = +data1, 3 = +data1+data2. 0 is treated as 1.
- `rs_en`  in  1: running-status enable, sampled at accept.
- `tx`  out  1: serial MIDI out, idle high.
- `busy`  out  1: high while any bit of a message is on the line.

## Operation
- Message FSM states: IDLE, STATUS, DATA1, DATA2.
  - IDLE: `msg_ready`=1. Accept occurs when `msg_valid && msg_ready`; status, data, len and `rs_en` are registered.
  - Transitions: IDLE→STATUS, or IDLE→DATA1 when running status suppresses the status byte. STATUS→DATA1 if len≥2, else →IDLE. DATA1→DATA2 if len=3, else →IDLE. DATA2→IDLE.
  - The FSM advances when the byte serializer reports `byte_done`.
- Byte serializer states: IDLE, START, DATA (8 bits, bit index 0..7), STOP. Each state lasts exactly `CLKS_PER_BIT` cycles. The tx level is 0, then d[i], then 1.
- `last_status` (8 bits, 0x00 = none) tracks running status:
  - Suppression: a status byte is suppressed iff `rs_en`=1, the status is in 0x80–0xEF, it equals `last_status`, and len≥2.
  - Sending 0x80–0xEF sets `last_status` to that status.
  - 0xF0–0xF7 clears `last_status` to 0x00.
  - 0xF8–0xFF (realtime) leaves `last_status` unchanged.
  - `last_status` updates at accept.
- An accepted message with `msg_status[7]`=0 is dropped. Nothing is transmitted, `last_status` is unchanged, and `msg_ready` reasserts on the next cycle.
- `busy` = (message FSM ≠ IDLE).

## Timing
- Reset values: `tx`=1, `msg_ready`=1, `busy`=0, both FSMs IDLE, `last_status`=0x00, counters 0.
- Reset asserted mid-byte forces `tx`=1 asynchronously. The partial frame is abandoned.
- Start bit begins (tx falls) on the clock edge following accept; latency is 1 cycle.
- Consecutive bytes within a message are back-to-back. The next start bit follows the last stop-bit cycle with zero idle cycles.
- Message duration: 10·`CLKS_PER_BIT`·N cycles, where N is the number of bytes transmitted.
- `msg_ready` rises on the cycle after the final stop-bit cycle. The earliest next start bit is one cycle after that accept, giving ≥1 idle-high cycle between messages.
- `msg_*` inputs are ignored while `msg_ready`=0. Only registered copies are used.
- The bit counter wraps `CLKS_PER_BIT-1`→0. Its width is `$clog2(CLKS_PER_BIT)`.

## Structure
- Package `midi_pkg`:
  - Constants `MIDI_BAUD` (31250), `MIDI_STATUS_MIN` (0x80), `MIDI_CHAN_MAX` (0xEF), `MIDI_SYSCOM_MAX` (0xF7).
  - FSM state enums for both FSMs.
- Sub-module `midi_byte_tx`: parameter `CLKS_PER_BIT`; ports `clk`, `rst_n`, `start`, `data[7:0]`, `tx`, `byte_done`, `idle`. The top FSM sequences bytes through it.

## Test plan
Use `CLKS_PER_BIT`=16 for speed, plus one run at default parameters.
- Note-on 0x90/0x3C/0x64, len 3, rs_en 0 → 30 bits on tx matching frames 0x90, 0x3C, 0x64 LSB first. `msg_ready` low for exactly 480 cycles (48000 at default), then high.
- Same message repeated with rs_en 1 → only 0x3C, 0x64 sent (20 bits, 320 cycles). Message 0x80/0x3C/0x00 next → status 0x80 sent.
- 0x90 msg, then realtime 0xF8 len 1, then 0x90 msg with rs_en 1 → second note-on sends 2 bytes. 0xF2 in place of 0xF8 → status resent.
- `msg_status`=0x45, valid → no tx activity, `msg_ready` low for 1 cycle, `last_status` unchanged.
- `rst_n` pulsed low during data bit 3 → tx=1 immediately, `busy`=0, `msg_ready`=1. Next 0x90 is sent in full even with rs_en 1.
- `msg_len`=0 with 0xFE → single 10-bit frame. `msg_valid` held high continuously → messages separated by exactly 1 idle cycle.
